// File: rtl/fifo_wr_arbiter.sv
// Packet-granularity round-robin arbiter sharing one asynch_fifo write port between two sources.
// Optional per-source completed-packet counters are built when FIFO_ARB_PKTCNT_EN is defined.
module fifo_wr_arbiter #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int PTR    = 4,
    parameter int MAXPKT = 8
) (
    input  logic             wrclk,
    input  logic             reset,
    input  logic             s0_valid,
    input  logic [WIDTH-1:0] s0_data,
    input  logic             s0_eop,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [WIDTH-1:0] s1_data,
    input  logic             s1_eop,
    output logic             s1_ready,
    output logic             fifo_wren,
    output logic [WIDTH-1:0] fifo_datain,
    input  logic             fifo_wrfull,
    input  logic [PTR:0]     fifo_wrusedw,
    output logic [1:0]       grant,
    output logic             err_ovl,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1
);

    localparam int                LEN_W    = $clog2(MAXPKT) + 1;
    localparam logic [LEN_W-1:0]  LEN_LAST = LEN_W'(MAXPKT - 1);
    localparam logic [PTR+1:0]    DEPTH_W  = (PTR+2)'(DEPTH);
    localparam logic [PTR+1:0]    MAXPKT_W = (PTR+2)'(MAXPKT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_s;
    logic [LEN_W-1:0] len_r;
    logic             last_r;
    logic [PTR+1:0]   free_s;
    logic             admit_s;
    logic             word_eop_s;
    logic             close_s;
    logic             trunc_s;

    assign free_s  = DEPTH_W - {1'b0, fifo_wrusedw};
    assign admit_s = (free_s >= MAXPKT_W);

    // Next-state decode plus the combinational handshake/write path of the owner.
    always_comb begin
        next_s      = state_r;
        s0_ready    = 1'b0;
        s1_ready    = 1'b0;
        fifo_wren   = 1'b0;
        fifo_datain = {WIDTH{1'b0}};
        grant       = 2'b00;
        word_eop_s  = 1'b0;
        close_s     = 1'b0;
        trunc_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // last_r==1 means source 1 was served last, so source 0 wins a tie.
                if (admit_s && s0_valid && s1_valid) begin
                    next_s = last_r ? OWN0 : OWN1;
                end else if (admit_s && s0_valid) begin
                    next_s = OWN0;
                end else if (admit_s && s1_valid) begin
                    next_s = OWN1;
                end else begin
                    next_s = IDLE;
                end
            end
            OWN0: begin
                grant       = 2'b01;
                s0_ready    = !fifo_wrfull && !reset;
                fifo_wren   = s0_valid && s0_ready;
                fifo_datain = s0_data;
                word_eop_s  = s0_eop;
            end
            OWN1: begin
                grant       = 2'b10;
                s1_ready    = !fifo_wrfull && !reset;
                fifo_wren   = s1_valid && s1_ready;
                fifo_datain = s1_data;
                word_eop_s  = s1_eop;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
        // An accepted eop word, or the MAXPKT-th word, closes the packet.
        if (fifo_wren && (word_eop_s || (len_r == LEN_LAST))) begin
            close_s = 1'b1;
            trunc_s = !word_eop_s;
            next_s  = IDLE;
        end else begin
            close_s = 1'b0;
            trunc_s = 1'b0;
        end
    end

    // State, word counter, round-robin history and truncation pulse.
    always_ff @(posedge wrclk) begin
        if (reset) begin
            state_r <= IDLE;
            len_r   <= {LEN_W{1'b0}};
            last_r  <= 1'b1;
            err_ovl <= 1'b0;
        end else begin
            state_r <= next_s;
            if (state_r == IDLE) begin
                len_r <= {LEN_W{1'b0}};
            end else if (fifo_wren) begin
                len_r <= len_r + LEN_W'(1);
            end else begin
                len_r <= len_r;
            end
            if (close_s) begin
                last_r <= (state_r == OWN1);
            end else begin
                last_r <= last_r;
            end
            err_ovl <= trunc_s;
        end
    end

`ifdef FIFO_ARB_PKTCNT_EN
    logic [15:0] pkt_cnt0_r;
    logic [15:0] pkt_cnt1_r;

    // Completed-packet counters; truncated packets count as completed.
    always_ff @(posedge wrclk) begin
        if (reset) begin
            pkt_cnt0_r <= 16'h0000;
            pkt_cnt1_r <= 16'h0000;
        end else begin
            if (close_s && (state_r == OWN0)) begin
                pkt_cnt0_r <= pkt_cnt0_r + 16'h0001;
            end else begin
                pkt_cnt0_r <= pkt_cnt0_r;
            end
            if (close_s && (state_r == OWN1)) begin
                pkt_cnt1_r <= pkt_cnt1_r + 16'h0001;
            end else begin
                pkt_cnt1_r <= pkt_cnt1_r;
            end
        end
    end

    assign pkt_cnt0 = pkt_cnt0_r;
    assign pkt_cnt1 = pkt_cnt1_r;
`else
    assign pkt_cnt0 = 16'h0000;
    assign pkt_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected FIFO writes, a monitor
// pops and compares them on every fifo_wren; directed checks cover grant timing and corner cases.
module tb_fifo_wr_arbiter;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int PTR    = 4;
    localparam int MAXPKT = 8;
`ifdef FIFO_ARB_PKTCNT_EN
    localparam bit PKTCNT_EN = 1'b1;
`else
    localparam bit PKTCNT_EN = 1'b0;
`endif

    logic             wrclk = 1'b0;
    logic             reset;
    logic             s0_valid, s0_eop, s0_ready;
    logic             s1_valid, s1_eop, s1_ready;
    logic [WIDTH-1:0] s0_data, s1_data;
    logic             fifo_wren;
    logic [WIDTH-1:0] fifo_datain;
    logic             fifo_wrfull;
    logic [PTR:0]     fifo_wrusedw;
    logic [1:0]       grant;
    logic             err_ovl;
    logic [15:0]      pkt_cnt0, pkt_cnt1;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .MAXPKT(MAXPKT)) dut (
        .wrclk(wrclk), .reset(reset),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_eop(s0_eop), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_eop(s1_eop), .s1_ready(s1_ready),
        .fifo_wren(fifo_wren), .fifo_datain(fifo_datain),
        .fifo_wrfull(fifo_wrfull), .fifo_wrusedw(fifo_wrusedw),
        .grant(grant), .err_ovl(err_ovl), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 wrclk = ~wrclk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int pc0 = 0;
    int pc1 = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] exp_q[$];
    logic acc0 = 1'b0;
    logic acc1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wrclk);
        #1;
    endtask

    task automatic send(input int src, input logic [7:0] d, input logic eop);
        if (src == 0) begin
            q0.push_back({eop, d});
            exp_q.push_back({2'b01, d});
        end else begin
            q1.push_back({eop, d});
            exp_q.push_back({2'b10, d});
        end
    endtask

    task automatic wait_word(input logic [7:0] d, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge wrclk);
            if (fifo_wren && fifo_datain == d) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge wrclk);
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && grant == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] pc_exp(input int n);
        return PKTCNT_EN ? 32'(n & 16'hFFFF) : 32'd0;
    endfunction

    // Handshake capture away from the active edge.
    always @(negedge wrclk) begin
        acc0 = s0_valid & s0_ready;
        acc1 = s1_valid & s1_ready;
    end

    // Scoreboard monitor: every FIFO write must match the next expected {grant,data}.
    always @(negedge wrclk) begin
        if (err_ovl) err_seen++;
        if (fifo_wren) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {22'd0, grant, fifo_datain}, 32'hFFFF);
            end else begin
                chk("write_grant_data", {22'd0, grant, fifo_datain}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // Source drivers: run after stimulus in each cycle so pushes are seen the same cycle.
    initial begin
        s0_valid = 1'b0; s0_data = 8'h00; s0_eop = 1'b0;
        s1_valid = 1'b0; s1_data = 8'h00; s1_eop = 1'b0;
        forever begin
            @(posedge wrclk);
            #2;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            s0_valid = (q0.size() > 0);
            {s0_eop, s0_data} = s0_valid ? q0[0] : 9'h000;
            s1_valid = (q1.size() > 0);
            {s1_eop, s1_data} = s1_valid ? q1[0] : 9'h000;
        end
    end

    initial begin
        int e0;
        reset = 1'b1; fifo_wrfull = 1'b0; fifo_wrusedw = 5'd0;
        tick(); tick();
        @(negedge wrclk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_ready0", {31'd0, s0_ready}, 32'd0);
        chk("rst_wren", {31'd0, fifo_wren}, 32'd0);
        chk("rst_err", {31'd0, err_ovl}, 32'd0);
        chk("rst_pkt0", {16'd0, pkt_cnt0}, 32'd0);
        tick(); reset = 1'b0;

        // 3-word packet from s0
        tick();
        send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b0); send(0, 8'hA3, 1'b1);
        @(negedge wrclk);
        chk("t1_idle_cycle", {30'd0, grant}, 32'd0);
        @(negedge wrclk);
        chk("t1_grant", {30'd0, grant}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t1_wren_run", {31'd0, fifo_wren}, 32'd1);
            @(negedge wrclk);
        end
        pc0++;
        chk("t1_back_idle", {30'd0, grant}, 32'd0);
        chk("t1_pkt0", {16'd0, pkt_cnt0}, pc_exp(pc0));
        wait_idle("t1_drain");

        // Reset so s0 wins first, then alternating 2-word packets
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; pc0 = 0; pc1 = 0;
        q0.push_back({1'b0, 8'hB1}); q0.push_back({1'b1, 8'hB2});
        q0.push_back({1'b0, 8'hB3}); q0.push_back({1'b1, 8'hB4});
        q1.push_back({1'b0, 8'hC1}); q1.push_back({1'b1, 8'hC2});
        q1.push_back({1'b0, 8'hC3}); q1.push_back({1'b1, 8'hC4});
        exp_q.push_back({2'b01, 8'hB1}); exp_q.push_back({2'b01, 8'hB2});
        exp_q.push_back({2'b10, 8'hC1}); exp_q.push_back({2'b10, 8'hC2});
        exp_q.push_back({2'b01, 8'hB3}); exp_q.push_back({2'b01, 8'hB4});
        exp_q.push_back({2'b10, 8'hC3}); exp_q.push_back({2'b10, 8'hC4});
        wait_idle("t2_drain");
        pc0 += 2; pc1 += 2;
        chk("t2_pkt0", {16'd0, pkt_cnt0}, pc_exp(pc0));
        chk("t2_pkt1", {16'd0, pkt_cnt1}, pc_exp(pc1));

        // Admission threshold: free=7 blocks, free=8 admits
        tick(); fifo_wrusedw = 5'd9;
        send(0, 8'hD1, 1'b0); send(0, 8'hD2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge wrclk);
            chk("t3_no_grant", {30'd0, grant}, 32'd0);
            chk("t3_no_ready", {31'd0, s0_ready}, 32'd0);
        end
        tick(); fifo_wrusedw = 5'd8;
        @(negedge wrclk);
        chk("t3_decide_cycle", {30'd0, grant}, 32'd0);
        @(negedge wrclk);
        chk("t3_grant", {30'd0, grant}, 32'd1);
        wait_idle("t3_drain");
        pc0++;
        tick(); fifo_wrusedw = 5'd0;

        // s1 stalled by wrfull for 4 cycles after word 2
        send(1, 8'hE1, 1'b0); send(1, 8'hE2, 1'b0); send(1, 8'hE3, 1'b0); send(1, 8'hE4, 1'b1);
        wait_word(8'hE2, "t4_word2_seen");
        tick(); fifo_wrfull = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge wrclk);
            chk("t4_stall_ready", {31'd0, s1_ready}, 32'd0);
            chk("t4_stall_wren", {31'd0, fifo_wren}, 32'd0);
            chk("t4_stall_grant", {30'd0, grant}, 32'd2);
        end
        tick(); fifo_wrfull = 1'b0;
        @(negedge wrclk);
        chk("t4_resume_wren", {31'd0, fifo_wren}, 32'd1);
        chk("t4_resume_data", {24'd0, fifo_datain}, 32'hE3);
        wait_idle("t4_drain");
        pc1++;
        chk("t4_pkt1", {16'd0, pkt_cnt1}, pc_exp(pc1));

        // Truncation at MAXPKT: 8 words, forced close, remaining words as a new packet
        tick();
        e0 = err_seen;
        for (int i = 0; i < 10; i++) send(0, 8'(8'h61 + i), (i == 9) ? 1'b1 : 1'b0);
        wait_word(8'h68, "t5_word8_seen");
        @(negedge wrclk);
        pc0++;
        chk("t5_trunc_idle", {30'd0, grant}, 32'd0);
        chk("t5_err_pulse", {31'd0, err_ovl}, 32'd1);
        chk("t5_pkt0", {16'd0, pkt_cnt0}, pc_exp(pc0));
        @(negedge wrclk);
        chk("t5_regrant", {30'd0, grant}, 32'd1);
        chk("t5_err_clear", {31'd0, err_ovl}, 32'd0);
        wait_idle("t5_drain");
        pc0++;
        chk("t5_err_once", 32'(err_seen - e0), 32'd1);

        // Reset mid-packet on word 2
        tick();
        send(0, 8'h71, 1'b0); send(0, 8'h72, 1'b0); send(0, 8'h73, 1'b1);
        wait_word(8'h71, "t6_word1_seen");
        tick(); reset = 1'b1;
        @(negedge wrclk);
        chk("t6_rst_ready", {31'd0, s0_ready}, 32'd0);
        chk("t6_rst_wren", {31'd0, fifo_wren}, 32'd0);
        tick(); reset = 1'b0;
        q0.delete(); exp_q.delete();
        pc0 = 0; pc1 = 0;
        send(0, 8'h81, 1'b0); send(0, 8'h82, 1'b1); send(1, 8'h91, 1'b1);
        @(negedge wrclk);
        chk("t6_after_grant", {30'd0, grant}, 32'd0);
        chk("t6_after_pkt0", {16'd0, pkt_cnt0}, 32'd0);
        @(negedge wrclk);
        chk("t6_s0_first", {30'd0, grant}, 32'd1);
        wait_idle("t6_drain");
        pc0++; pc1++;
        chk("t6_pkt0", {16'd0, pkt_cnt0}, pc_exp(pc0));
        chk("t6_pkt1", {16'd0, pkt_cnt1}, pc_exp(pc1));
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_err_total", 32'(err_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
